// File: rtl/nios2_imem_server.sv
// -----------------------------------------------------------------------------
// nios2_imem_server
//
// Instruction memory for the nios_2 core. A host streams a program in over a
// valid/ready loader port; afterwards the core fetches words with a one-cycle
// registered response. Addresses at or beyond the number of words loaded read
// back as NOP_WORD, which also hides stale contents left over from earlier
// loads (the array itself is never cleared).
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   ld_start    pulse: begin a new load at address 0
//   ld_valid    loader beat valid
//   ld_ready    beat can be accepted (high only while loading)
//   ld_data     instruction word of the current beat
//   ld_last     final beat of the load
//   ld_done     one-cycle pulse in the first cycle after the load completes
//   load_count  number of words loaded, 0..2^ADDR_W
//   enable      fetch request from the core
//   prog_count  fetch address from the core
//   inst_fetch  registered instruction word to the core
//   inst_valid  inst_fetch was updated by a fetch on the last edge
// -----------------------------------------------------------------------------
module nios2_imem_server #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = 32'h0001883A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_done,
  output logic [ADDR_W:0]   load_count,
  input  logic              enable,
  input  logic [ADDR_W-1:0] prog_count,
  output logic [DATA_W-1:0] inst_fetch,
  output logic              inst_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  // State and storage
  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W:0]   load_count_r;
  logic              ld_ready_r;
  logic              ld_done_r;
  logic [DATA_W-1:0] inst_fetch_r;
  logic              inst_valid_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Derived control
  logic              accept_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [ADDR_W:0]   base_count_s;
  logic              beat_last_s;
  logic              fetch_s;
  logic              hit_s;

  // Beat acceptance and write addressing. A start pulse in the same cycle as
  // an accepted beat rewinds first, so that beat lands at address 0.
  always_comb begin
    accept_s     = 1'b0;
    wr_addr_s    = wr_ptr_r;
    base_count_s = load_count_r;
    beat_last_s  = 1'b0;
    if (state_r == ST_LOAD) begin
      accept_s = ld_valid;
    end else begin
      accept_s = 1'b0;
    end
    if (ld_start) begin
      wr_addr_s    = '0;
      base_count_s = '0;
    end else begin
      wr_addr_s    = wr_ptr_r;
      base_count_s = load_count_r;
    end
    // Load ends on an explicit last beat or when the final array slot is
    // written (pointer wraps, count reaches DEPTH).
    if (accept_s && (ld_last || (wr_addr_s == PTR_LAST))) begin
      beat_last_s = 1'b1;
    end else begin
      beat_last_s = 1'b0;
    end
  end

  // Fetch qualification; load_count is zero-extended-compared so a full load
  // makes every address valid.
  always_comb begin
    fetch_s = 1'b0;
    hit_s   = 1'b0;
    if (state_r == ST_READY) begin
      fetch_s = enable;
    end else begin
      fetch_s = 1'b0;
    end
    if ({1'b0, prog_count} < load_count_r) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ld_start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A completing beat wins even if it arrives with a restart pulse.
        if (beat_last_s) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_READY: begin
        if (ld_start) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_READY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered loader handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ld_ready_r <= 1'b0;
      ld_done_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ld_ready_r <= (state_nxt_s == ST_LOAD);
      ld_done_r  <= beat_last_s;
    end
  end

  // Write pointer and loaded-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      load_count_r <= '0;
    end else if (accept_s) begin
      wr_ptr_r     <= wr_addr_s + PTR_ONE;
      load_count_r <= base_count_s + CNT_ONE;
    end else if (ld_start) begin
      wr_ptr_r     <= '0;
      load_count_r <= '0;
    end else begin
      wr_ptr_r     <= wr_ptr_r;
      load_count_r <= load_count_r;
    end
  end

  // Instruction array write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      mem_r[wr_addr_s] <= ld_data;
    end
  end

  // Registered fetch response; output holds when no fetch is serviced
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_fetch_r <= NOP_WORD;
      inst_valid_r <= 1'b0;
    end else if (fetch_s) begin
      inst_fetch_r <= hit_s ? mem_r[prog_count] : NOP_WORD;
      inst_valid_r <= 1'b1;
    end else begin
      inst_fetch_r <= inst_fetch_r;
      inst_valid_r <= 1'b0;
    end
  end

  assign ld_ready   = ld_ready_r;
  assign ld_done    = ld_done_r;
  assign load_count = load_count_r;
  assign inst_fetch = inst_fetch_r;
  assign inst_valid = inst_valid_r;

endmodule

// File: tb/tb_nios2_imem_server.sv
// -----------------------------------------------------------------------------
// tb_nios2_imem_server
//
// Directed bench for nios2_imem_server. Fetch expectations are queued when a
// fetch is issued; a negedge monitor pops and compares whenever inst_valid is
// high. Loader-side outputs are checked directly 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_nios2_imem_server;

  localparam logic [31:0] NOP = 32'h0001883A;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_done;
  logic [8:0]  load_count;
  logic        enable;
  logic [7:0]  prog_count;
  logic [31:0] inst_fetch;
  logic        inst_valid;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  nios2_imem_server #(
    .ADDR_W  (8),
    .DATA_W  (32),
    .NOP_WORD(32'h0001883A)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_done   (ld_done),
    .load_count(load_count),
    .enable    (enable),
    .prog_count(prog_count),
    .inst_fetch(inst_fetch),
    .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected word, present the address for one edge.
  task automatic fetch(input logic [7:0] a, input logic [31:0] e);
    enable     = 1'b1;
    prog_count = a;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic load_seq(input int n, input logic [31:0] base, input bit use_last);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + i;
      ld_last  = use_last && (i == n - 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (ld_done === 1'b1) done_cnt++;
    if (inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_fetch: got inst_valid=1 data=%0h expected no response", inst_fetch);
      end else begin
        check("fetch", {32'b0, inst_fetch}, {32'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 32'h0;
    ld_last = 1'b0; enable = 1'b0; prog_count = 8'h0;

    // 1. reset values
    tick(); tick();
    check("rst_inst_fetch", inst_fetch, NOP);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_load_count", load_count, 0);
    check("rst_ld_done", ld_done, 0);
    rst = 1'b0;

    // 2. short load and fetch
    load_seq(8, 32'h3000_0000, 1'b1);
    check("s2_ld_done", ld_done, 1);
    check("s2_load_count", load_count, 8);
    check("s2_ld_ready", ld_ready, 0);
    tick();
    check("s2_ld_done_clear", ld_done, 0);
    check("s2_done_pulses", done_cnt, 1);
    for (int i = 0; i < 8; i++) fetch(i[7:0], 32'h3000_0000 + i);

    // 3. unloaded address, then hold with enable low
    fetch(8'd8, NOP);
    fetch(8'd3, 32'h3000_0003);
    enable = 1'b0;
    repeat (3) begin
      tick();
      check("s3_hold_data", inst_fetch, 32'h3000_0003);
      check("s3_hold_valid", inst_valid, 0);
    end

    // 4. full-depth wrap
    load_seq(256, 32'h4000_0000, 1'b0);
    check("s4_load_count", load_count, 256);
    check("s4_ld_done", ld_done, 1);
    check("s4_ld_ready", ld_ready, 0);
    fetch(8'd255, 32'h4000_00FF);
    fetch(8'd0, 32'h4000_0000);
    enable = 1'b0;
    tick();
    check("s4_ld_ready_after", ld_ready, 0);
    check("s4_done_pulses", done_cnt, 2);

    // 5. restart priority: start+beat in LOAD writes address 0
    load_seq(5, 32'h5000_0000, 1'b0);
    check("s5_partial_count", load_count, 5);
    check("s5_partial_ready", ld_ready, 1);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    check("s5_restart_count", load_count, 1);
    check("s5_ld_done", ld_done, 1);
    fetch(8'd1, NOP);
    fetch(8'd0, 32'hDEAD_BEEF);
    enable = 1'b0;
    tick();

    // 6. reset mid-load
    load_seq(3, 32'h6000_0000, 1'b0);
    check("s6_partial_count", load_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_rst_count", load_count, 0);
    check("s6_rst_ready", ld_ready, 0);
    check("s6_rst_inst_fetch", inst_fetch, NOP);
    check("s6_rst_inst_valid", inst_valid, 0);
    enable = 1'b1; prog_count = 8'd0;
    repeat (3) begin
      tick();
      check("s6_idle_no_fetch", inst_valid, 0);
    end
    enable = 1'b0;
    load_seq(2, 32'h7000_0000, 1'b1);
    check("s6_reload_count", load_count, 2);
    fetch(8'd0, 32'h7000_0000);
    fetch(8'd1, 32'h7000_0001);
    fetch(8'd2, NOP);
    enable = 1'b0;
    tick(); tick();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
